// File: rtl/gpio_hs_ports_pkg.sv
// Shared definitions for the gpio_hs_ports register block.
//   Register offsets: DATA_p / DDR_p sit at 2p / 2p+1; ICR, IMR and the
//   optional ESTAT_p / EMASK_p registers are offsets from B = 2*NUM_PORTS.
//   ICR bit positions and the CIA-style set/clear update used for IMR.
package gpio_hs_ports_pkg;

  localparam int unsigned OFF_DATA  = 0;  // + 2p
  localparam int unsigned OFF_DDR   = 1;  // + 2p
  localparam int unsigned OFF_ICR   = 0;  // + B
  localparam int unsigned OFF_IMR   = 1;  // + B
  localparam int unsigned OFF_ESTAT = 2;  // + B + 2p
  localparam int unsigned OFF_EMASK = 3;  // + B + 2p

  localparam logic [2:0] ICR_FLAG = 3'd0;
  localparam logic [2:0] ICR_EDGE = 3'd1;
  localparam logic [2:0] ICR_IRQ  = 3'd7;
  localparam logic [2:0] IMR_SC   = 3'd7;  // 1 = set selected bits, 0 = clear

  // Bit 7 of the written byte chooses set or clear; bits 1:0 select which
  // mask bits are affected. Bits outside 'valid' never change.
  function automatic logic [1:0] imr_update(input logic [1:0] cur,
                                            input logic [7:0] wr,
                                            input logic [1:0] valid);
    logic [1:0] sel;
    sel = wr[1:0] & valid;
    return wr[IMR_SC] ? (cur | sel) : (cur & ~sel);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Two-flop input synchroniser with single-cycle edge pulses.
//   i_clk, i_reset : clock and synchronous active-high reset (clears all flops)
//   i_d            : asynchronous inputs
//   o_q            : synchronised value (2 cycles behind i_d)
//   o_rise/o_fall  : one-cycle pulses when o_q goes 0->1 / 1->0
module gpio_sync_edge #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;  // previous synchronised value, for edge detection

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/gpio_hs_ports.sv
// Multi-port GPIO block with data direction registers, pc_n handshake strobe
// and a flag_n / pin-edge interrupt source on an 8-bit register bus.
//   clk, reset        : clock, synchronous active-high reset
//   cs, we, addr, din : register bus (access on rising clk when cs=1)
//   dout              : registered read data, held between reads
//   gpio_i/o/oe       : pins; port p occupies [p*PORT_W +: PORT_W]
//   flag_n            : asynchronous low-true FLAG input (falling edge sets ICR[0])
//   pc_n              : low for one cycle after any access to DATA_HS_PORT
//   irq_n             : registered low-true interrupt request
// Optional feature macro: GPIO_EDGE_IRQ_EN adds per-pin rising-edge status
// (ESTAT_p, write-1-to-clear) and masks (EMASK_p) feeding ICR[1].
module gpio_hs_ports
  import gpio_hs_ports_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 2,
  parameter int unsigned PORT_W    = 8,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned HS_PORT   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cs,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [7:0]                  din,
  output logic [7:0]                  dout,
  input  logic [NUM_PORTS*PORT_W-1:0] gpio_i,
  output logic [NUM_PORTS*PORT_W-1:0] gpio_o,
  output logic [NUM_PORTS*PORT_W-1:0] gpio_oe,
  input  logic                        flag_n,
  output logic                        pc_n,
  output logic                        irq_n
);

  localparam int unsigned B = 2 * NUM_PORTS;
`ifdef GPIO_EDGE_IRQ_EN
  localparam logic [1:0] IMR_VALID = 2'b11;
`else
  localparam logic [1:0] IMR_VALID = 2'b01;
`endif

  logic [PORT_W-1:0]    r_data        [NUM_PORTS];
  logic [PORT_W-1:0]    r_ddr         [NUM_PORTS];
  logic [PORT_W-1:0]    w_sync        [NUM_PORTS];
  logic [PORT_W-1:0]    w_rise        [NUM_PORTS];
  logic [PORT_W-1:0]    w_unused_fall [NUM_PORTS];
  logic                 r_icr_flag;
  logic [1:0]           r_imr;
  logic [7:0]           r_dout;
  logic                 r_pc_n;
  logic                 r_irq_n;
  logic [31:0]          w_a;
  logic                 w_rd;
  logic                 w_wr;
  logic [NUM_PORTS-1:0] w_data_sel;
  logic [NUM_PORTS-1:0] w_ddr_sel;
  logic                 w_icr_sel;
  logic                 w_imr_sel;
  logic                 w_flag_fall;
  logic                 w_unused_flag_q;
  logic                 w_unused_flag_rise;
  logic                 w_edge_any;
  logic                 w_irq;
  logic [7:0]           w_icr_rd;
  logic [7:0]           w_rdata;

  assign w_a  = 32'(addr);
  assign w_rd = cs & ~we;
  assign w_wr = cs & we;

  // Input synchronisers and pin drivers
  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
    gpio_sync_edge #(.W(PORT_W)) u_sync (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (gpio_i[gp*PORT_W +: PORT_W]),
      .o_q     (w_sync[gp]),
      .o_rise  (w_rise[gp]),
      .o_fall  (w_unused_fall[gp])
    );
    assign gpio_o [gp*PORT_W +: PORT_W] = r_data[gp];
    assign gpio_oe[gp*PORT_W +: PORT_W] = r_ddr[gp];
  end

  gpio_sync_edge #(.W(1)) u_flag_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_d     (flag_n),
    .o_q     (w_unused_flag_q),
    .o_rise  (w_unused_flag_rise),
    .o_fall  (w_flag_fall)
  );

`ifdef GPIO_EDGE_IRQ_EN
  logic [NUM_PORTS-1:0] w_estat_sel;
  logic [NUM_PORTS-1:0] w_emask_sel;
  logic [PORT_W-1:0]    r_estat [NUM_PORTS];
  logic [PORT_W-1:0]    r_emask [NUM_PORTS];
  logic [PORT_W-1:0]    w_w1c   [NUM_PORTS];

  always_comb begin
    w_edge_any = 1'b0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_estat_sel[p] = (w_a == B + OFF_ESTAT + 2*p);
      w_emask_sel[p] = (w_a == B + OFF_EMASK + 2*p);
      w_w1c[p]       = (w_wr && w_estat_sel[p]) ? din[PORT_W-1:0] : '0;
      w_edge_any     = w_edge_any | (|(r_estat[p] & r_emask[p]));
    end
  end

  // A rising edge landing in the same cycle as a W1C re-sets the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_estat[p] <= '0;
        r_emask[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_estat[p] <= (r_estat[p] & ~w_w1c[p]) | w_rise[p];
        if (w_wr && w_emask_sel[p]) r_emask[p] <= din[PORT_W-1:0];
      end
    end
  end
`else
  logic [PORT_W-1:0] w_unused_rise [NUM_PORTS];
  always_comb w_unused_rise = w_rise;
  assign w_edge_any = 1'b0;
`endif

  always_comb begin
    w_data_sel = '0;
    w_ddr_sel  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      w_data_sel[p] = (w_a == 2*p + OFF_DATA);
      w_ddr_sel[p]  = (w_a == 2*p + OFF_DDR);
    end
    w_icr_sel = (w_a == B + OFF_ICR);
    w_imr_sel = (w_a == B + OFF_IMR);
  end

  assign w_irq = (r_icr_flag & r_imr[0]) | (w_edge_any & r_imr[1]);

  always_comb begin
    w_icr_rd           = '0;
    w_icr_rd[ICR_IRQ]  = w_irq;
    w_icr_rd[ICR_EDGE] = w_edge_any;
    w_icr_rd[ICR_FLAG] = r_icr_flag;
  end

  // Read mux; anything not decoded reads 0.
  always_comb begin
    w_rdata = 8'h00;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (w_data_sel[p]) w_rdata = 8'((r_data[p] & r_ddr[p]) | (w_sync[p] & ~r_ddr[p]));
      if (w_ddr_sel[p])  w_rdata = 8'(r_ddr[p]);
`ifdef GPIO_EDGE_IRQ_EN
      if (w_estat_sel[p]) w_rdata = 8'(r_estat[p]);
      if (w_emask_sel[p]) w_rdata = 8'(r_emask[p]);
`endif
    end
    if (w_icr_sel) w_rdata = w_icr_rd;
    if (w_imr_sel) w_rdata = {6'b0, r_imr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        r_data[p] <= '0;
        r_ddr[p]  <= '0;
      end
    end else if (w_wr) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (w_data_sel[p]) r_data[p] <= din[PORT_W-1:0];
        if (w_ddr_sel[p])  r_ddr[p]  <= din[PORT_W-1:0];
      end
    end
  end

  // ICR read clears the flag, but a falling edge arriving in that same
  // cycle still sets it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_imr      <= '0;
      r_icr_flag <= 1'b0;
      r_dout     <= '0;
      r_pc_n     <= 1'b1;
      r_irq_n    <= 1'b1;
    end else begin
      if (w_wr && w_imr_sel) r_imr <= imr_update(r_imr, din, IMR_VALID);
      r_icr_flag <= (r_icr_flag & ~(w_rd & w_icr_sel)) | w_flag_fall;
      if (w_rd) r_dout <= w_rdata;
      r_pc_n  <= ~(cs & w_data_sel[HS_PORT]);
      r_irq_n <= ~w_irq;
    end
  end

  assign dout  = r_dout;
  assign pc_n  = r_pc_n;
  assign irq_n = r_irq_n;

endmodule

// File: tb/tb_gpio_hs_ports.sv
// Self-checking bench for gpio_hs_ports (NUM_PORTS=2, PORT_W=8, ADDR_W=5, HS_PORT=1).
// A cycle-level behavioural model tracks registers and pin-sample history; every
// clock the DUT outputs are compared with it, with extra directed checks on
// the documented scenarios.
module tb_gpio_hs_ports;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [4:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic [15:0] gpio_i;
  logic [15:0] gpio_o;
  logic [15:0] gpio_oe;
  logic        flag_n;
  logic        pc_n;
  logic        irq_n;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef GPIO_EDGE_IRQ_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  always #5 clk = ~clk;

  gpio_hs_ports #(.NUM_PORTS(2), .PORT_W(8), .ADDR_W(5), .HS_PORT(1)) dut (
    .clk(clk), .reset(reset), .cs(cs), .we(we), .addr(addr), .din(din),
    .dout(dout), .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe),
    .flag_n(flag_n), .pc_n(pc_n), .irq_n(irq_n)
  );

  // Reference model state
  logic [7:0]  m_data [2];
  logic [7:0]  m_ddr  [2];
  logic [7:0]  m_estat[2];
  logic [7:0]  m_emask[2];
  logic [1:0]  m_imr;
  logic        m_flag;
  logic [7:0]  m_dout;
  logic        m_pc_n;
  logic        m_irq_n;
  logic [15:0] g_hist [3];  // pin samples at the last three edges, newest first
  logic        f_hist [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_reg(input logic [4:0] a, input logic [15:0] sg,
                                       input logic irq, input logic eany);
    logic [7:0] s;
    int p;
    m_reg = 8'h00;
    if (a < 5'd4) begin
      p = int'(a) / 2;
      s = (p == 0) ? sg[7:0] : sg[15:8];
      m_reg = a[0] ? m_ddr[p] : ((m_data[p] & m_ddr[p]) | (s & ~m_ddr[p]));
    end else if (a == 5'd4) begin
      m_reg = {irq, 5'b0, eany, m_flag};
    end else if (a == 5'd5) begin
      m_reg = {6'b0, m_imr};
    end else if (EDGE && a >= 5'd6 && a <= 5'd9) begin
      p = (int'(a) - 6) / 2;
      m_reg = a[0] ? m_emask[p] : m_estat[p];
    end
  endfunction

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    logic [15:0] sg, rise;
    logic        fall, eany, irq;
    logic [1:0]  sel;
    logic [7:0]  w1c;
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        m_data[p] = 0; m_ddr[p] = 0; m_estat[p] = 0; m_emask[p] = 0;
      end
      m_imr = 0; m_flag = 0; m_dout = 0; m_pc_n = 1; m_irq_n = 1;
      for (int k = 0; k < 3; k++) begin g_hist[k] = 0; f_hist[k] = 0; end
      return;
    end
    sg   = g_hist[1];
    rise = g_hist[1] & ~g_hist[2];
    fall = f_hist[2] & ~f_hist[1];
    eany = EDGE && (|({m_estat[1], m_estat[0]} & {m_emask[1], m_emask[0]}));
    irq  = (m_flag & m_imr[0]) | (eany & m_imr[1]);
    if (cs && !we) m_dout = m_reg(addr, sg, irq, eany);
    m_pc_n  = !(cs && addr == 5'd2);
    m_irq_n = !irq;
    m_flag  = (m_flag && !(cs && !we && addr == 5'd4)) || fall;
    if (EDGE) begin
      for (int p = 0; p < 2; p++) begin
        w1c = (cs && we && addr == 5'(6 + 2*p)) ? din : 8'h00;
        m_estat[p] = (m_estat[p] & ~w1c) | rise[8*p +: 8];
      end
    end
    if (cs && we) begin
      case (addr)
        5'd0: m_data[0] = din;
        5'd1: m_ddr[0]  = din;
        5'd2: m_data[1] = din;
        5'd3: m_ddr[1]  = din;
        5'd5: begin
          sel   = din[1:0] & (EDGE ? 2'b11 : 2'b01);
          m_imr = din[7] ? (m_imr | sel) : (m_imr & ~sel);
        end
        5'd7: if (EDGE) m_emask[0] = din;
        5'd9: if (EDGE) m_emask[1] = din;
        default: ;
      endcase
    end
    g_hist[2] = g_hist[1]; g_hist[1] = g_hist[0]; g_hist[0] = gpio_i;
    f_hist[2] = f_hist[1]; f_hist[1] = f_hist[0]; f_hist[0] = flag_n;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    chk("dout",    dout,    m_dout);
    chk("pc_n",    pc_n,    m_pc_n);
    chk("irq_n",   irq_n,   m_irq_n);
    chk("gpio_o",  gpio_o,  {m_data[1], m_data[0]});
    chk("gpio_oe", gpio_oe, {m_ddr[1], m_ddr[0]});
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    cs = 1; we = 1; addr = a; din = d;
    cycle();
    cs = 0; we = 0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [7:0] v);
    cs = 1; we = 0; addr = a;
    cycle();
    cs = 0;
    v = dout;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dout"},    dout,    32'h00);
    chk({tag, "_gpio_o"},  gpio_o,  32'h0000);
    chk({tag, "_gpio_oe"}, gpio_oe, 32'h0000);
    chk({tag, "_pc_n"},    pc_n,    32'h1);
    chk({tag, "_irq_n"},   irq_n,   32'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    reset = 1; cs = 0; we = 0; addr = 0; din = 0; gpio_i = 0; flag_n = 1;
    cycle(); cycle();
    chk_reset_outputs("reset");
    reset = 0; gpio_i = 16'h0030;
    repeat (3) cycle();

    // Direction and data registers, mixed-direction read-back
    bus_write(5'd1, 8'h0F);
    bus_write(5'd0, 8'hA5);
    chk("t1_oe", gpio_oe[7:0], 8'h0F);
    chk("t1_o",  gpio_o[7:0],  8'hA5);
    bus_read(5'd0, v);
    chk("t1_data0", v, 8'h35);

    // pc_n handshake strobe
    bus_read(5'd2, v);
    chk("t2_pc_low", pc_n, 1'b0);
    cycle();
    chk("t2_pc_back", pc_n, 1'b1);
    bus_read(5'd0, v);
    chk("t2_pc_data0", pc_n, 1'b1);
    cs = 1; we = 0; addr = 5'd2;
    cycle(); cycle();
    chk("t2_b2b_low", pc_n, 1'b0);
    cs = 0;
    cycle();
    chk("t2_b2b_end", pc_n, 1'b1);

    // FLAG interrupt and ICR read-clear
    bus_write(5'd5, 8'h81);
    flag_n = 0;
    repeat (3) cycle();
    chk("t3_irq_wait", irq_n, 1'b1);
    cycle();
    chk("t3_irq_set", irq_n, 1'b0);
    bus_read(5'd4, v);
    chk("t3_icr_first", v, 8'h81);
    bus_read(5'd4, v);
    chk("t3_icr_second", v, 8'h00);
    chk("t3_irq_clear", irq_n, 1'b1);

    // ICR read in the same cycle the flag edge lands
    flag_n = 1;
    repeat (4) cycle();
    flag_n = 0;
    cycle(); cycle();
    bus_read(5'd4, v);
    chk("t4_icr_same", v, 8'h00);
    bus_read(5'd4, v);
    chk("t4_icr_kept", v, 8'h81);

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      cs     = 1'($urandom_range(0, 1));
      we     = 1'($urandom_range(0, 1));
      addr   = 5'($urandom_range(0, 11));
      din    = 8'($urandom);
      gpio_i = 16'($urandom);
      flag_n = 1'($urandom);
      cycle();
    end
    cs = 0; we = 0;

    // Reset while irq_n and pc_n are both asserted
    bus_write(5'd5, 8'h81);
    flag_n = 1;
    repeat (4) cycle();
    flag_n = 0;
    repeat (4) cycle();
    bus_read(5'd2, v);
    chk("t6_pre_irq", irq_n, 1'b0);
    chk("t6_pre_pc",  pc_n,  1'b0);
    gpio_i = 0; flag_n = 1;
    reset = 1;
    cycle();
    chk_reset_outputs("t6_reset");
    reset = 0;
    repeat (3) cycle();

`ifdef GPIO_EDGE_IRQ_EN
    // Pin edge status and interrupt
    bus_write(5'd9, 8'h04);
    bus_write(5'd5, 8'h82);
    gpio_i[10] = 1'b1;
    repeat (4) cycle();
    bus_read(5'd8, v);
    chk("t5_estat1", v, 8'h04);
    chk("t5_irq", irq_n, 1'b0);
    bus_write(5'd8, 8'h04);
    bus_read(5'd8, v);
    chk("t5_estat1_clr", v, 8'h00);
    chk("t5_irq_clr", irq_n, 1'b1);
`else
    // Edge registers absent: addresses unmapped, IMR[1] stuck at 0
    bus_write(5'd8, 8'h5A);
    bus_read(5'd8, v);
    chk("t6_estat_unmapped", v, 8'h00);
    bus_write(5'd5, 8'h82);
    bus_read(5'd5, v);
    chk("t6_imr1_zero", v, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
